toggle_cover_collector: RTL and testbench
=========================================

# toggle_cover_collector

Synthesizable receiving end of the toggle-coverage reporting path: it accepts the same per-cycle `valid` hit vector that toggle cover reporters consume, accumulates hits into a sticky bitmap, and counts distinct points covered. On request it streams a snapshot of the bitmap, tagged with global cover indices, over a valid/ready interface. This lets formal harnesses and FPGA/emulation builds without DPI read coverage back.

## Interface
- `WIDTH`, 29: number of cover points in this group (1..1024).
- `COVER_INDEX`, 0: global index of bit 0; added to every reported index.
- `RD_W`, 8: readout word width in bits (1..64).
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  reset is asynchronous and active-high.
- `valid`  in  WIDTH  per-cycle hit vector; bit i = cover point COVER_INDEX+i hit this cycle.
- `clear`  in  1  synchronous pulse: zero bitmap and counter.
- `dump_start`  in  1  pulse: snapshot bitmap and begin readout.
- `busy`  out  1  readout in progress (state SEND).
- `out_valid`  out  1  readout beat valid.
- `out_ready`  in  1  sink accepts beat.
- `out_index`  out  64  global index of `out_data[0]`.
- `out_data`  out  RD_W  bitmap slice.
- `out_last`  out  1  final beat of dump.
- `hit_count`  out  clog2(WIDTH+1)  number of distinct points hit.
- `new_hit`  out  1  registered pulse: at least one first-time hit last cycle.
- `all_covered`  out  1  `hit_count == WIDTH`.

## Operation
- Bitmap `hits[WIDTH]`, sticky. Each cycle: `fresh = valid & ~hits`; `hits <= hits | valid`; `hit_count <= hit_count + popcount(fresh)`; `new_hit <= |fresh`.
- Counter cannot overflow (saturates naturally at WIDTH); popcount evaluated over full WIDTH in one cycle.
- `clear`: `hits`, `hit_count`, `new_hit` go to 0; clear beats `valid` in the same cycle (that cycle's hits are discarded).
- Readout FSM, states IDLE, SEND. NW = ceil(WIDTH/RD_W) words; beat k carries `snap[k*RD_W +: RD_W]`, bits beyond WIDTH read 0; `out_index = COVER_INDEX + k*RD_W`.
- IDLE --`dump_start`--> SEND: `snap <= hits | valid` (that cycle's hits included, `clear` ignored for the snapshot), k = 0.
- SEND: `out_valid` = 1; on `out_valid & out_ready`, k++; on accepted beat with k = NW-1 (`out_last` = 1) -> IDLE.
- `dump_start` ignored while in SEND, including the final-beat cycle.
- Accumulation and `clear` continue during SEND and never alter `snap`.
- `out_data`, `out_index`, `out_last` stable while `out_valid & !out_ready`.

## Timing
- Reset (async, immediate): `hits`, `snap`, `hit_count`, `new_hit`, `busy`, `out_valid`, `out_last`, `out_data`, `out_index` = 0; state IDLE. Reset mid-dump aborts it; no resume.
- `hit_count`, `new_hit`, `all_covered` reflect `valid` of cycle t at cycle t+1.
- `dump_start` at t -> `busy`, `out_valid` high at t+1 with beat 0.
- Sink ready every cycle: NW beats on consecutive cycles t+1..t+NW; `busy` low at t+NW+1; a new `dump_start` is accepted from t+NW+1.
- No combinational path from `out_ready` to `out_valid`.

## Test plan
- Reset with `valid` = all ones toggling -> all outputs 0 while reset high; dropping reset mid-cycle leaves them 0 until next edge.
- WIDTH=29: `valid`=bit0|bit28 at t, bit0 at t+1 -> `hit_count`=2 at t+1 and stays 2; `new_hit` high only at t+1.
- `valid`=0x1FFFFFFF one cycle -> `hit_count`=29, `all_covered`=1 next cycle; then `clear` with `valid`=bit3 -> `hit_count`=0, `all_covered`=0.
- COVER_INDEX=100, RD_W=8, hits bits 0,9,28, `dump_start` -> beats (100,0x01),(108,0x02),(116,0x00),(124,0x10,last); `out_ready` low 3 cycles at beat 1 -> beat held unchanged.
- `clear` and new `valid` bits during SEND -> dumped data equals snapshot; `hit_count` reflects post-clear hits; `dump_start` during SEND ignored (exactly 4 beats).
- Assert `reset` while beat 2 pending -> `out_valid`, `busy` drop immediately; after release, `dump_start` gives beat 0 with all-zero data.

Source files
------------

// File: rtl/toggle_cover_collector.sv
// rtl/toggle_cover_collector.sv - sticky toggle-coverage bitmap with hit counter and valid/ready snapshot readout
//
// Ports:
//   clock, reset     sole clock; asynchronous active-high reset
//   valid[WIDTH]     per-cycle hit vector, bit i = cover point COVER_INDEX+i
//   clear            synchronous pulse zeroing bitmap, counter and new_hit
//   dump_start       pulse: snapshot bitmap (plus this cycle's hits) and stream it out
//   busy             readout in progress
//   out_valid/out_ready/out_index/out_data/out_last
//                    readout beats; out_index is the global index of out_data[0]
//   hit_count        number of distinct cover points hit
//   new_hit          registered pulse: a first-time hit occurred last cycle
//   all_covered      every cover point has been hit
module toggle_cover_collector #(
  parameter int WIDTH       = 29,
  parameter int COVER_INDEX = 0,
  parameter int RD_W        = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           valid,
  input  logic                       clear,
  input  logic                       dump_start,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_index,
  output logic [RD_W-1:0]            out_data,
  output logic                       out_last,
  output logic [$clog2(WIDTH+1)-1:0] hit_count,
  output logic                       new_hit,
  output logic                       all_covered
);

  localparam int HCW = $clog2(WIDTH + 1);
  localparam int NW  = (WIDTH + RD_W - 1) / RD_W;
  localparam int SW  = NW * RD_W;
  localparam int KW  = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  logic [WIDTH-1:0] hits;
  logic [SW-1:0]    snap;
  logic [KW-1:0]    k;

  logic [WIDTH-1:0] fresh;
  logic [HCW-1:0]   fresh_cnt;
  logic [SW-1:0]    snap_next;
  logic [KW-1:0]    k_next;
  logic [63:0]      next_index;
  logic [RD_W-1:0]  next_data;

  always_comb begin
    fresh     = valid & ~hits;
    fresh_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fresh_cnt = fresh_cnt + HCW'(fresh[i]);
    end
    // Snapshot is padded to whole words so bits past WIDTH read back as 0.
    snap_next              = '0;
    snap_next[WIDTH-1:0]   = hits | valid;
    k_next                 = k + 1'b1;
    next_index             = 64'(COVER_INDEX) + 64'(k_next) * 64'(RD_W);
    next_data              = snap[32'(k_next) * 32'(RD_W) +: RD_W];
  end

  assign all_covered = (hit_count == HCW'(WIDTH));

  // Accumulation; clear wins over the same cycle's hits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hits      <= '0;
      hit_count <= '0;
      new_hit   <= 1'b0;
    end else if (clear) begin
      hits      <= '0;
      hit_count <= '0;
      new_hit   <= 1'b0;
    end else begin
      hits      <= hits | valid;
      hit_count <= hit_count + fresh_cnt;
      new_hit   <= |fresh;
    end
  end

  // Readout FSM; all beat fields are registered so out_ready never reaches out_valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      snap      <= '0;
      k         <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_start) begin
            state     <= SEND;
            snap      <= snap_next;
            k         <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_index <= 64'(COVER_INDEX);
            out_data  <= snap_next[RD_W-1:0];
            out_last  <= (NW == 1) ? 1'b1 : 1'b0;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              out_index <= '0;
            end else begin
              k         <= k_next;
              out_index <= next_index;
              out_data  <= next_data;
              out_last  <= (k_next == KW'(NW - 1)) ? 1'b1 : 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_cover_collector.sv
// tb/tb_toggle_cover_collector.sv - directed self-checking bench for toggle_cover_collector
module tb_toggle_cover_collector;

  localparam int WIDTH = 29;
  localparam int CIDX  = 100;
  localparam int RD_W  = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [WIDTH-1:0]  valid;
  logic              clear;
  logic              dump_start;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_index;
  logic [RD_W-1:0]   out_data;
  logic              out_last;
  logic [4:0]        hit_count;
  logic              new_hit;
  logic              all_covered;

  int checks = 0;
  int errors = 0;

  toggle_cover_collector #(.WIDTH(WIDTH), .COVER_INDEX(CIDX), .RD_W(RD_W)) dut (
    .clock(clock), .reset(reset), .valid(valid), .clear(clear),
    .dump_start(dump_start), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_data(out_data),
    .out_last(out_last), .hit_count(hit_count), .new_hit(new_hit),
    .all_covered(all_covered)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] idx, input logic [7:0] data, input logic last);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, " out_index"}, out_index, idx);
    chk({tag, " out_data"}, 64'(out_data), 64'(data));
    chk({tag, " out_last"}, 64'(out_last), 64'(last));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " hit_count"}, 64'(hit_count), 64'd0);
    chk({tag, " new_hit"}, 64'(new_hit), 64'd0);
    chk({tag, " all_covered"}, 64'(all_covered), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " out_last"}, 64'(out_last), 64'd0);
    chk({tag, " out_data"}, 64'(out_data), 64'd0);
    chk({tag, " out_index"}, out_index, 64'd0);
  endtask

  initial begin
    reset = 1'b1; valid = '0; clear = 1'b0; dump_start = 1'b0; out_ready = 1'b0;

    // Reset held with valid toggling and dump_start pulsing: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      valid = (i % 2 == 0) ? '1 : '0;
      dump_start = 1'b1;
      tick();
      chk_zero("reset_hold");
    end
    #4;
    reset = 1'b0; valid = '0; dump_start = 1'b0;
    #1;
    chk_zero("reset_release_midcycle");
    tick();
    chk_zero("after_release_edge");

    // Sticky counting.
    valid = 29'h1000_0001;
    tick();
    chk("cnt_first hit_count", 64'(hit_count), 64'd2);
    chk("cnt_first new_hit", 64'(new_hit), 64'd1);
    valid = 29'h0000_0001;
    tick();
    chk("cnt_repeat hit_count", 64'(hit_count), 64'd2);
    chk("cnt_repeat new_hit", 64'(new_hit), 64'd0);
    valid = '0;
    tick();
    chk("cnt_idle hit_count", 64'(hit_count), 64'd2);

    // Full coverage, then clear beating same-cycle valid.
    valid = 29'h1FFF_FFFF;
    tick();
    chk("full hit_count", 64'(hit_count), 64'd29);
    chk("full all_covered", 64'(all_covered), 64'd1);
    chk("full new_hit", 64'(new_hit), 64'd1);
    valid = 29'h0000_0008; clear = 1'b1;
    tick();
    chk("clear hit_count", 64'(hit_count), 64'd0);
    chk("clear all_covered", 64'(all_covered), 64'd0);
    chk("clear new_hit", 64'(new_hit), 64'd0);
    valid = '0; clear = 1'b0;
    tick();
    chk("clear_discard hit_count", 64'(hit_count), 64'd0);

    // Hits on bits 0, 9, 28 then dump.
    valid = 29'h1000_0201;
    tick();
    chk("pre_dump hit_count", 64'(hit_count), 64'd3);
    valid = '0; dump_start = 1'b1;
    tick();
    chk("dump busy", 64'(busy), 64'd1);
    chk_beat("beat0", 64'd100, 8'h01, 1'b0);
    dump_start = 1'b0; out_ready = 1'b1;
    tick();
    chk_beat("beat1", 64'd108, 8'h02, 1'b0);

    // Stall three cycles on beat 1 with clear, new hits and an ignored dump_start.
    out_ready = 1'b0; clear = 1'b1; valid = 29'h0000_0020;
    tick();
    chk_beat("stall1", 64'd108, 8'h02, 1'b0);
    chk("stall1 hit_count", 64'(hit_count), 64'd0);
    clear = 1'b0; valid = 29'h0010_0000; dump_start = 1'b1;
    tick();
    chk_beat("stall2", 64'd108, 8'h02, 1'b0);
    chk("stall2 hit_count", 64'(hit_count), 64'd1);
    valid = '0; dump_start = 1'b0;
    tick();
    chk_beat("stall3", 64'd108, 8'h02, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_beat("beat2", 64'd116, 8'h00, 1'b0);
    tick();
    chk_beat("beat3", 64'd124, 8'h10, 1'b1);
    dump_start = 1'b1;
    tick();
    chk("end busy", 64'(busy), 64'd0);
    chk("end out_valid", 64'(out_valid), 64'd0);
    dump_start = 1'b0;
    tick();
    chk("no_redump out_valid", 64'(out_valid), 64'd0);
    chk("post_clear hit_count", 64'(hit_count), 64'd1);

    // Reset in the middle of a dump (hits now bit 20 only -> word 2 = 0x10).
    dump_start = 1'b1;
    tick();
    chk_beat("d2_beat0", 64'd100, 8'h00, 1'b0);
    dump_start = 1'b0;
    tick();
    chk_beat("d2_beat1", 64'd108, 8'h00, 1'b0);
    tick();
    chk_beat("d2_beat2", 64'd116, 8'h10, 1'b0);
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_zero("mid_dump_reset");
    tick();
    reset = 1'b0;
    tick();
    chk_zero("after_abort");
    dump_start = 1'b1;
    tick();
    chk("d3 busy", 64'(busy), 64'd1);
    chk_beat("d3_beat0", 64'd100, 8'h00, 1'b0);
    dump_start = 1'b0; out_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      tick();
      chk_beat("d3_beat", 64'(100 + 8 * b), 8'h00, (b == 3) ? 1'b1 : 1'b0);
    end
    tick();
    chk("d3 end busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
